// File: rtl/rx_sipo_frame_if.sv
// rtl/rx_sipo_frame_if.sv - bit-sampler / consumer bus for the receive deserialiser
//
// Carries the bit stream, frame configuration, and output word handshake.
//   shift, serial_in       : sampled bit from the receive bit-sampling control
//   clear                  : synchronous frame abort
//   data_bits, parity_mode : frame configuration, sampled at frame start
//   data_ack               : consumer accepts the held word
//   parallel_out           : last completed word, right-aligned
//   data_valid             : held word not yet acknowledged
//   parity_err             : parity mismatch on the held word
//   overrun                : sticky, a frame completed over an unacknowledged word
//   busy                   : a frame is in progress
// Modports: master = stimulus/consumer side, slave = deserialiser.
interface rx_sipo_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  shift;
  logic                  serial_in;
  logic                  clear;
  logic [3:0]            data_bits;
  logic [1:0]            parity_mode;
  logic                  data_ack;
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    output shift, serial_in, clear, data_bits, parity_mode, data_ack,
    input  parallel_out, data_valid, parity_err, overrun, busy
  );

  modport slave (
    input  shift, serial_in, clear, data_bits, parity_mode, data_ack,
    output parallel_out, data_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/rx_sipo_frame.sv
// rtl/rx_sipo_frame.sv - parametrised UART receive serial-to-parallel deserialiser
//
// Assembles 1..DATA_WIDTH data bits (LSB- or MSB-first) into a right-aligned
// word, optionally checks even/odd parity, and holds the result under a
// valid/ack handshake with sticky overrun detection.
// Ports:
//   rx_clk : sole clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : rx_sipo_frame_if slave modport (bit stream, config, word handshake)
module rx_sipo_frame #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic           rx_clk,
  input  logic           rst,
  rx_sipo_frame_if.slave bus
);

  localparam logic [3:0] WIDTH4 = 4'(DATA_WIDTH);
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } state_t;

  state_t state, state_n;

  logic [3:0]            count;
  logic [3:0]            n_lat;
  logic [1:0]            par_lat;
  logic [DATA_WIDTH-1:0] shreg;

  logic [DATA_WIDTH-1:0] out_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ovr_q;

  // Per-cycle view of the frame: in IDLE the frame would start now, so the
  // live configuration inputs apply; afterwards the latched copies do.
  logic [3:0]            n_start;
  logic [3:0]            cur_n;
  logic [3:0]            cur_cnt;
  logic [1:0]            cur_par;
  logic [3:0]            bit_idx;
  logic                  par_en;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] word_new;
  logic [DATA_WIDTH-1:0] word_out;
  logic                  par_bad;
  logic                  err_n;

  logic start;
  logic store;
  logic complete;

  always_comb begin
    if (bus.data_bits == 4'd0 || bus.data_bits > WIDTH4) begin
      n_start = WIDTH4;
    end else begin
      n_start = bus.data_bits;
    end
  end

  assign cur_n    = (state == S_IDLE) ? n_start         : n_lat;
  assign cur_par  = (state == S_IDLE) ? bus.parity_mode : par_lat;
  assign cur_cnt  = (state == S_IDLE) ? 4'd0            : count;
  assign par_en   = (cur_par == PAR_EVEN) || (cur_par == PAR_ODD);
  assign last_bit = ((cur_cnt + 4'd1) == cur_n);
  assign bit_idx  = LSB_FIRST ? cur_cnt : (cur_n - 4'd1 - cur_cnt);

  // Start from an empty register on frame start so bits from an earlier or
  // aborted frame can never appear in the new word. Only indices below N are
  // ever written, which keeps the unused high bits at 0.
  always_comb begin
    word_new = start ? '0 : shreg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (store && bit_idx == i[3:0]) begin
        word_new[i] = bus.serial_in;
      end
    end
  end

  assign par_bad  = (^shreg) ^ bus.serial_in;
  assign err_n    = (state == S_PARITY) ? ((cur_par == PAR_EVEN) ? par_bad : ~par_bad) : 1'b0;
  assign word_out = (state == S_PARITY) ? shreg : word_new;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    store    = 1'b0;
    complete = 1'b0;
    if (bus.clear) begin
      // Abort wins over a coincident shift; the bit is dropped.
      state_n = S_IDLE;
    end else if (bus.shift) begin
      unique case (state)
        S_IDLE, S_DATA: begin
          start = (state == S_IDLE);
          store = 1'b1;
          if (!last_bit) begin
            state_n = S_DATA;
          end else if (par_en) begin
            state_n = S_PARITY;
          end else begin
            state_n  = S_IDLE;
            complete = 1'b1;
          end
        end
        S_PARITY: begin
          state_n  = S_IDLE;
          complete = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      count   <= 4'd0;
      n_lat   <= 4'd0;
      par_lat <= 2'b00;
      shreg   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (bus.clear) begin
        count <= 4'd0;
      end else if (bus.shift) begin
        if (start) begin
          n_lat   <= n_start;
          par_lat <= bus.parity_mode;
        end
        if (complete) begin
          count <= 4'd0;
        end else if (start) begin
          count <= 4'd1;
        end else if (state == S_DATA) begin
          count <= count + 4'd1;
        end
        if (store) begin
          shreg <= word_new;
        end
      end

      // Handshake is independent of clear: a consumer ack still lands.
      if (complete) begin
        out_q   <= word_out;
        perr_q  <= err_n;
        valid_q <= 1'b1;
      end else if (bus.data_ack) begin
        valid_q <= 1'b0;
      end

      if (bus.clear) begin
        ovr_q <= 1'b0;
      end else if (complete && valid_q && !bus.data_ack) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign bus.parallel_out = out_q;
  assign bus.data_valid   = valid_q;
  assign bus.parity_err   = perr_q;
  assign bus.overrun      = ovr_q;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_rx_sipo_frame.sv
// tb/tb_rx_sipo_frame.sv - directed table-driven bench for rx_sipo_frame
module tb_rx_sipo_frame;

  logic       rx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift = 1'b0;
  logic       serial_in = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity_mode = 2'b00;
  logic       data_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 rx_clk = ~rx_clk;

  rx_sipo_frame_if #(.DATA_WIDTH(8)) if_l ();
  rx_sipo_frame_if #(.DATA_WIDTH(8)) if_m ();

  assign if_l.shift       = shift;
  assign if_l.serial_in   = serial_in;
  assign if_l.clear       = clear;
  assign if_l.data_bits   = data_bits;
  assign if_l.parity_mode = parity_mode;
  assign if_l.data_ack    = data_ack;
  assign if_m.shift       = shift;
  assign if_m.serial_in   = serial_in;
  assign if_m.clear       = clear;
  assign if_m.data_bits   = data_bits;
  assign if_m.parity_mode = parity_mode;
  assign if_m.data_ack    = data_ack;

  rx_sipo_frame #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .rx_clk (rx_clk),
    .rst    (rst),
    .bus    (if_l.slave)
  );

  rx_sipo_frame #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .rx_clk (rx_clk),
    .rst    (rst),
    .bus    (if_m.slave)
  );

  typedef struct {
    logic [15:0] seq;      // bit i is the i-th bit shifted in
    int          nshift;
    logic [3:0]  db;
    logic [1:0]  pm;
    bit          msb;
    logic [7:0]  exp_out;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] seq, input int n, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      shift     = 1'b1;
      serial_in = seq[i];
      data_ack  = ack_last && (i == n - 1);
      tick();
    end
    shift     = 1'b0;
    serial_in = 1'b0;
    data_ack  = 1'b0;
  endtask

  task automatic ack_once();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  initial begin
    //               seq       n  db     pm     msb   out    perr
    vecs[0]  = '{16'h00A5, 8, 4'd8,  2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[1]  = '{16'h000D, 5, 4'd5,  2'b00, 1'b1, 8'h16, 1'b0};
    vecs[2]  = '{16'h008D, 8, 4'd0,  2'b00, 1'b1, 8'hB1, 1'b0};
    vecs[3]  = '{16'h008D, 8, 4'd12, 2'b00, 1'b1, 8'hB1, 1'b0};
    vecs[4]  = '{16'h0041, 8, 4'd7,  2'b01, 1'b0, 8'h41, 1'b0};
    vecs[5]  = '{16'h0041, 8, 4'd7,  2'b10, 1'b0, 8'h41, 1'b1};
    vecs[6]  = '{16'h00C1, 8, 4'd7,  2'b10, 1'b0, 8'h41, 1'b0};
    vecs[7]  = '{16'h00C1, 8, 4'd7,  2'b01, 1'b0, 8'h41, 1'b1};
    vecs[8]  = '{16'h0001, 1, 4'd1,  2'b00, 1'b0, 8'h01, 1'b0};
    vecs[9]  = '{16'h0006, 4, 4'd3,  2'b01, 1'b0, 8'h06, 1'b0};
    vecs[10] = '{16'h003C, 8, 4'd9,  2'b00, 1'b0, 8'h3C, 1'b0};
    vecs[11] = '{16'h00F5, 4, 4'd4,  2'b11, 1'b0, 8'h05, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    check("reset_out",   int'(if_l.parallel_out), 0);
    check("reset_valid", int'(if_l.data_valid), 0);
    check("reset_perr",  int'(if_l.parity_err), 0);
    check("reset_ovr",   int'(if_l.overrun), 0);
    check("reset_busy",  int'(if_l.busy), 0);

    for (int i = 0; i < 12; i++) begin
      data_bits   = vecs[i].db;
      parity_mode = vecs[i].pm;
      send_frame(vecs[i].seq, vecs[i].nshift, 1'b0);
      if (vecs[i].msb) begin
        check($sformatf("vec%0d_out", i),   int'(if_m.parallel_out), int'(vecs[i].exp_out));
        check($sformatf("vec%0d_valid", i), int'(if_m.data_valid), 1);
        check($sformatf("vec%0d_perr", i),  int'(if_m.parity_err), int'(vecs[i].exp_perr));
        check($sformatf("vec%0d_busy", i),  int'(if_m.busy), 0);
      end else begin
        check($sformatf("vec%0d_out", i),   int'(if_l.parallel_out), int'(vecs[i].exp_out));
        check($sformatf("vec%0d_valid", i), int'(if_l.data_valid), 1);
        check($sformatf("vec%0d_perr", i),  int'(if_l.parity_err), int'(vecs[i].exp_perr));
        check($sformatf("vec%0d_busy", i),  int'(if_l.busy), 0);
      end
      ack_once();
      check($sformatf("vec%0d_ack", i), int'(if_l.data_valid), 0);
    end

    // Overrun: second frame back-to-back over an unacknowledged word.
    data_bits   = 4'd8;
    parity_mode = 2'b00;
    send_frame(16'h0011, 8, 1'b0);
    check("ovr_first", int'(if_l.overrun), 0);
    send_frame(16'h0022, 8, 1'b0);
    check("ovr_set",   int'(if_l.overrun), 1);
    check("ovr_out",   int'(if_l.parallel_out), 'h22);
    check("ovr_valid", int'(if_l.data_valid), 1);

    // Abort three bits in, clear coincident with a shift.
    send_frame(16'h0000, 3, 1'b0);
    check("abort_busy_mid", int'(if_l.busy), 1);
    shift = 1'b1;
    clear = 1'b1;
    tick();
    shift = 1'b0;
    clear = 1'b0;
    check("abort_busy",  int'(if_l.busy), 0);
    check("abort_ovr",   int'(if_l.overrun), 0);
    check("abort_out",   int'(if_l.parallel_out), 'h22);
    check("abort_valid", int'(if_l.data_valid), 1);
    ack_once();
    send_frame(16'h00FF, 8, 1'b0);
    check("after_abort_out", int'(if_l.parallel_out), 'hFF);
    ack_once();

    // Ack on the completion cycle: word replaced, no overrun.
    send_frame(16'h0033, 8, 1'b0);
    check("ackc_first_ovr", int'(if_l.overrun), 0);
    send_frame(16'h0044, 8, 1'b1);
    check("ackc_out",   int'(if_l.parallel_out), 'h44);
    check("ackc_valid", int'(if_l.data_valid), 1);
    check("ackc_ovr",   int'(if_l.overrun), 0);
    ack_once();

    // Width change mid-frame is ignored until the next frame.
    data_bits = 4'd4;
    shift     = 1'b1;
    serial_in = 1'b1;
    tick();
    data_bits = 4'd8;
    send_frame(16'h0005, 3, 1'b0);
    check("cfg_valid", int'(if_l.data_valid), 1);
    check("cfg_out",   int'(if_l.parallel_out), 'h0B);
    check("cfg_busy",  int'(if_l.busy), 0);

    // Reset mid-frame while a word is held.
    send_frame(16'h000F, 4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out",   int'(if_l.parallel_out), 0);
    check("rst_valid", int'(if_l.data_valid), 0);
    check("rst_perr",  int'(if_l.parity_err), 0);
    check("rst_ovr",   int'(if_l.overrun), 0);
    check("rst_busy",  int'(if_l.busy), 0);
    send_frame(16'h005A, 8, 1'b0);
    check("post_rst_out",   int'(if_l.parallel_out), 'h5A);
    check("post_rst_valid", int'(if_l.data_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_sipo_frame.md
# rx_sipo_frame

Parametrised serial-to-parallel receive deserialiser for the UART receive path, the successor to the fixed 8-bit SIPO. It assembles a run-time-selectable number of data bits (LSB- or MSB-first) into a right-aligned word. It optionally checks an even or odd parity bit, then holds the word under a valid/ack handshake with overrun detection. It sits between the receive bit-sampling control, which drives `shift`/`serial_in`, and the receive buffer or host interface.

## Interface
- `DATA_WIDTH`, default 8: maximum data bits per frame and width of `parallel_out`. Legal range is 1..15.
- `LSB_FIRST`, default 1: 1 means the first received bit lands in bit 0; 0 means the first received bit lands in bit `data_bits-1`.
- `rx_clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `clear`  input  1  synchronous abort: returns to IDLE and clears `overrun`; does not touch `parallel_out`, `data_valid` or `parity_err`.
- `shift`  input  1  sample `serial_in` this cycle.
- `serial_in`  input  1  received bit, valid when `shift`=1.
- `data_bits`  input  4  data bits per frame, sampled at frame start. A value of 0 or greater than `DATA_WIDTH` is treated as `DATA_WIDTH`.
- `parity_mode`  input  2  parity selection, sampled at frame start: 00 = none, 01 = even, 10 = odd, 11 = none.
- `data_ack`  input  1  consumer accepts the held word.
- `parallel_out`  output  DATA_WIDTH  last completed word, right-aligned, with bits at and above `data_bits` forced to 0.
- `data_valid`  output  1  a word is held and not yet acknowledged.
- `parity_err`  output  1  parity mismatch on the word currently in `parallel_out`; 0 when parity is none.
- `overrun`  output  1  sticky; a frame completed while the previous word was still unacknowledged.
- `busy`  output  1  state is not IDLE.

## Operation
- States:
  - IDLE: no frame in progress.
  - DATA: data bits being collected.
  - PARITY: waiting for the parity bit.
- Reset values: state IDLE, bit counter 0, `parallel_out` 0, `data_valid` 0, `parity_err` 0, `overrun` 0, `busy` 0.
- IDLE, `shift`=1:
  - Latch the effective `data_bits` into N and latch `parity_mode`.
  - Store the bit and set count to 1.
  - Go to DATA. If N=1, apply the completion rule below directly from this cycle.
- DATA, `shift`=1:
  - Store the bit at index count (LSB_FIRST) or N-1-count (MSB_FIRST), then increment count.
  - When this is the N-th bit: with parity none, complete the frame and return to IDLE; otherwise go to PARITY.
- PARITY, `shift`=1: sample the parity bit, complete the frame and return to IDLE.
  - Even mode: error if XOR(data, parity bit) is 1.
  - Odd mode: error if XOR(data, parity bit) is 0.
- Completion:
  - Load `parallel_out` with the assembled word (unused high bits 0).
  - Load `parity_err` with the check result.
  - Set `data_valid`=1.
- Shift register: the internal shift register is cleared at every frame start, so stale bits never leak into a word.
- Handshake:
  - `data_valid` stays high until a cycle with `data_ack`=1; it clears at that edge.
  - `data_ack` while `data_valid`=0 is ignored.
- Overrun:
  - Completion while `data_valid`=1 and `data_ack`=0 sets `overrun`. The new word overwrites `parallel_out` and `data_valid` remains 1.
  - `overrun` clears only on `rst` or `clear`.
- Simultaneous events:
  - Completion and `data_ack` in the same cycle: new word loaded, `data_valid` stays 1, no overrun.
  - `clear` and `shift` in the same cycle: clear wins and the bit is discarded.
  - `rst` overrides everything.
- Mid-frame `clear` or `rst`: the partial frame is discarded and no completion occurs.
- Configuration changes: changing `data_bits` or `parity_mode` mid-frame has no effect until the next frame start.

## Timing
- Back-to-back `shift` on consecutive cycles is supported with no dead cycle between frames: a `shift` on the cycle after completion starts the next frame.
- Completion latency: `parallel_out`, `parity_err` and `data_valid` update at the rising edge that samples the final data bit (parity none) or the parity bit. They are visible in the following cycle.
- Minimum frame: N cycles with parity none, N+1 cycles with parity enabled.
- `busy` rises the cycle after the first `shift` and falls the cycle after completion, `clear` or `rst`.
- `shift`=0 cycles: state and count hold.

## Test plan
- Basic 8N1: DATA_WIDTH=8, LSB_FIRST=1, `data_bits`=8, parity none; shift bits of 0xA5 LSB-first on consecutive cycles.
  - Expect `parallel_out`=0xA5 and `data_valid`=1 one cycle after the 8th shift.
  - Then `data_ack` for one cycle: `data_valid`=0 on the next cycle.
- Width/order: `data_bits`=5, LSB_FIRST=0; shift 1,0,1,1,0.
  - Expect `parallel_out`=0x16 and bits 7:5 = 0.
  - Repeat with `data_bits`=0 and with 12: both behave as 8 bits.
- Parity: `data_bits`=7.
  - Even mode, data 0x41 with parity bit 0: `parity_err`=0, completion after the 8th shift.
  - Same frame in odd mode: `parity_err`=1.
- Overrun: complete 0x11 with no ack, then complete 0x22.
  - Expect `overrun`=1, `parallel_out`=0x22, `data_valid`=1.
  - Repeat with `data_ack` on the completion cycle: `overrun` stays 0.
- Abort: 3 bits into a frame, assert `clear` together with `shift`.
  - Expect `busy`=0 and `overrun`=0, with `parallel_out` unchanged.
  - A following full 8-bit frame of 0xFF reads back exactly 0xFF.
- Reset mid-frame: assert `rst` after 4 shifts while `data_valid`=1.
  - All outputs read 0 the next cycle.
  - A subsequent frame decodes correctly.
